// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multicycle RISC-V control path.
// Holds the FSM state encoding, the supported opcodes and the ALUOp codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } statetype;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic op_is_legal(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// Pure combinational decoder from FSM state to the datapath control word.
// rdy only gates the fetch-time IR/PC load.
module main_fsm_outdec
    import riscv_ctrl_pkg::*;
(
    input  statetype   state,
    input  logic       rdy,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp
);

    always_comb begin
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = rdy;
                PCUpdate  = rdy;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = ALUOP_SUB;
                Branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM: state register and next-state logic, with
// a memory-ready wait handshake and illegal-opcode detection in DECODE.
module main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal_instr,
    output logic [3:0] state
);

    statetype   state_q;
    statetype   state_n;
    statetype   dec_state;
    logic       rdy;
    logic       dec_pcupdate;
    logic       dec_branch;
    logic       dec_regwrite;
    logic       dec_memwrite;
    logic       dec_irwrite;

    assign rdy = (USE_MEM_READY == 0) ? 1'b1 : mem_ready;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = S_FETCH;
        case (state_q)
            S_FETCH:    state_n = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_R:         state_n = S_EXECUTER;
                    OP_I:         state_n = S_EXECUTEI;
                    OP_BEQ:       state_n = S_BEQ;
                    OP_JAL:       state_n = S_JAL;
                    default:      state_n = S_FETCH;
                endcase
            end
            S_MEMADR:   state_n = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_n = rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_n = S_FETCH;
            S_MEMWRITE: state_n = rdy ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_n = S_ALUWB;
            S_EXECUTEI: state_n = S_ALUWB;
            S_ALUWB:    state_n = S_FETCH;
            S_BEQ:      state_n = S_FETCH;
            S_JAL:      state_n = S_ALUWB;
            default:    state_n = S_FETCH;
        endcase
    end

    // During reset the selects look like FETCH while every write enable is held off.
    assign dec_state = reset ? S_FETCH : state_q;

    main_fsm_outdec u_outdec (
        .state     (dec_state),
        .rdy       (rdy),
        .PCUpdate  (dec_pcupdate),
        .Branch    (dec_branch),
        .RegWrite  (dec_regwrite),
        .MemWrite  (dec_memwrite),
        .IRWrite   (dec_irwrite),
        .AdrSrc    (AdrSrc),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp)
    );

    assign PCUpdate      = dec_pcupdate & ~reset;
    assign Branch        = dec_branch   & ~reset;
    assign RegWrite      = dec_regwrite & ~reset;
    assign MemWrite      = dec_memwrite & ~reset;
    assign IRWrite       = dec_irwrite  & ~reset;
    assign illegal_instr = ~reset & (state_q == S_DECODE) & ~op_is_legal(op);
    assign state         = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: each directed cycle pushes the expected state
// and control word; a negedge monitor pops and compares against the DUT.
module tb_main_fsm;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct {
        int          step;
        logic [3:0]  st;
        logic [14:0] ctrl;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       mem_ready;
    logic       PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] state;

    exp_t sb[$];
    int   stepNo    = 0;
    int   compared  = 0;
    int   mismatched = 0;

    main_fsm #(.USE_MEM_READY(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .mem_ready     (mem_ready),
        .PCUpdate      (PCUpdate),
        .Branch        (Branch),
        .RegWrite      (RegWrite),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .AdrSrc        (AdrSrc),
        .ResultSrc     (ResultSrc),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUOp         (ALUOp),
        .illegal_instr (illegal_instr),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word expected from the state table:
    // {PCUpdate,Branch,RegWrite,MemWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,illegal}
    function automatic logic [14:0] expCtrl(input logic [3:0] s, input logic rdy,
                                            input logic rst, input logic ill);
        logic       pcu, br, rw, mw, irw, adr, il;
        logic [1:0] res, sa, sbv, aop;
        logic [3:0] se;
        se  = rst ? 4'd0 : s;
        pcu = 0; br = 0; rw = 0; mw = 0; irw = 0; adr = 0; il = 0;
        res = 2'b00; sa = 2'b00; sbv = 2'b00; aop = 2'b00;
        case (se)
            4'd0:  begin sbv = 2'b10; res = 2'b10; irw = rdy; pcu = rdy; end
            4'd1:  begin sa = 2'b01; sbv = 2'b01; il = ill; end
            4'd2:  begin sa = 2'b10; sbv = 2'b01; end
            4'd3:  begin adr = 1'b1; end
            4'd4:  begin res = 2'b01; rw = 1'b1; end
            4'd5:  begin adr = 1'b1; mw = 1'b1; end
            4'd6:  begin sa = 2'b10; aop = 2'b10; end
            4'd7:  begin sa = 2'b10; sbv = 2'b01; aop = 2'b10; end
            4'd8:  begin rw = 1'b1; end
            4'd9:  begin sa = 2'b10; aop = 2'b01; br = 1'b1; end
            4'd10: begin sa = 2'b01; sbv = 2'b10; pcu = 1'b1; end
            default: ;
        endcase
        if (rst) begin pcu = 0; br = 0; rw = 0; mw = 0; irw = 0; il = 0; end
        return {pcu, br, rw, mw, irw, adr, res, sa, sbv, aop, il};
    endfunction

    // One cycle: drive inputs just after the edge and log what this cycle should show.
    task automatic applyStimulus(input logic rst, input logic [6:0] o, input logic mr,
                                 input logic [3:0] es, input logic ill);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        op        = o;
        mem_ready = mr;
        stepNo++;
        e.step = stepNo;
        e.st   = es;
        e.ctrl = expCtrl(es, mr, rst, ill);
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [14:0] act;
        e   = sb.pop_front();
        act = {PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, illegal_instr};
        compared++;
        if (state !== e.st) begin
            mismatched++;
            $display("[TB] FAIL step%0d_state: got %0d expected %0d", e.step, state, e.st);
        end
        compared++;
        if (act !== e.ctrl) begin
            mismatched++;
            $display("[TB] FAIL step%0d_ctrl: got %b expected %b", e.step, act, e.ctrl);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() != 0) checkOutput();
        end
    end

    initial begin
        reset     = 1'b1;
        op        = RT;
        mem_ready = 1'b1;
        // reset held two cycles, then release with rdy high
        applyStimulus(1, RT, 1, 4'd0, 0);
        applyStimulus(1, RT, 1, 4'd0, 0);
        applyStimulus(0, RT, 1, 4'd0, 0);
        // R-type
        applyStimulus(0, RT, 1, 4'd1, 0);
        applyStimulus(0, RT, 1, 4'd6, 0);
        applyStimulus(0, RT, 1, 4'd8, 0);
        // lw
        applyStimulus(0, LW, 1, 4'd0, 0);
        applyStimulus(0, LW, 1, 4'd1, 0);
        applyStimulus(0, LW, 1, 4'd2, 0);
        applyStimulus(0, LW, 1, 4'd3, 0);
        applyStimulus(0, LW, 1, 4'd4, 0);
        // sw with three wait cycles in MEMWRITE
        applyStimulus(0, SW, 1, 4'd0, 0);
        applyStimulus(0, SW, 1, 4'd1, 0);
        applyStimulus(0, SW, 1, 4'd2, 0);
        applyStimulus(0, SW, 0, 4'd5, 0);
        applyStimulus(0, SW, 0, 4'd5, 0);
        applyStimulus(0, SW, 0, 4'd5, 0);
        applyStimulus(0, SW, 1, 4'd5, 0);
        // beq
        applyStimulus(0, BQ, 1, 4'd0, 0);
        applyStimulus(0, BQ, 1, 4'd1, 0);
        applyStimulus(0, BQ, 1, 4'd9, 0);
        // jal
        applyStimulus(0, JL, 1, 4'd0, 0);
        applyStimulus(0, JL, 1, 4'd1, 0);
        applyStimulus(0, JL, 1, 4'd10, 0);
        applyStimulus(0, JL, 1, 4'd8, 0);
        // illegal opcode
        applyStimulus(0, BAD, 1, 4'd0, 0);
        applyStimulus(0, BAD, 1, 4'd1, 1);
        // fetch wait, then lw interrupted by reset while in MEMREAD
        applyStimulus(0, LW, 0, 4'd0, 0);
        applyStimulus(0, LW, 1, 4'd0, 0);
        applyStimulus(0, LW, 1, 4'd1, 0);
        applyStimulus(0, LW, 1, 4'd2, 0);
        applyStimulus(0, LW, 0, 4'd3, 0);
        applyStimulus(1, LW, 0, 4'd3, 0);
        applyStimulus(0, LW, 1, 4'd0, 0);
        // I-type, op changing outside DECODE/MEMADR is ignored
        applyStimulus(0, IT, 1, 4'd1, 0);
        applyStimulus(0, BAD, 1, 4'd7, 0);
        applyStimulus(0, BAD, 1, 4'd8, 0);
        applyStimulus(0, RT, 1, 4'd0, 0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
